multicycle_control_fsm: RTL
===========================

Name: multicycle_control_fsm

Overview:
- Main control unit for the multicycle 16-bit datapath; it is the producer of the 2-bit ALUop that the ALU control decoder consumes.
- Sequences fetch/decode/execute/memory/writeback per instruction from the 4-bit opcode and drives all datapath enables and mux selects.
- Waits on a memory ready handshake and halts on an illegal opcode.

Parameters:
- STATE_W, 4, width of state register and debug state output
- OPC_W, 4, opcode width (instr[15:12])

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high
- opcode  input  4  instr[15:12] from instruction register
- mem_ready  input  1  memory completes the current access this cycle
- zero  input  1  ALU zero flag, informational only
- PCWrite  output  1  unconditional PC load
- PCWriteCond  output  1  PC load if branch condition met
- BranchNE  output  1  0 = condition is zero, 1 = condition is !zero
- PCSource  output  2  0 ALU result, 1 ALUOut, 2 jump target
- IorD  output  1  0 PC address, 1 ALUOut address
- MemRead  output  1  memory read request
- MemWrite  output  1  memory write request
- IRWrite  output  1  load instruction register
- RegDst  output  1  0 rt, 1 rd
- MemtoReg  output  1  0 ALUOut, 1 MDR
- RegWrite  output  1  register file write
- ALUSrcA  output  1  0 PC, 1 register A
- ALUSrcB  output  2  0 B, 1 constant 1, 2 sign-extended imm, 3 zero-extended imm
- ALUop  output  2  0 add, 1 sub, 2 use func, 3 or
- state  output  4  current state, for debug
- halted  output  1  high while in HALT

Behaviour:
- Opcodes: 0 R-type, 1 addi, 2 ori, 3 lw, 4 sw, 5 beq, 6 bne, 7 j. 8–15 are illegal.
- States and encodings:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, REXEC=6, RWB=7
  - IEXEC=8, IWB=9, BRANCH=10, JUMP=11, HALT=12
  - Encodings 13–15 go to FETCH on the next cycle with all outputs 0.
- Outputs are combinational from the registered state, with gating by mem_ready where stated. Any output not listed for a state is 0.
- FETCH:
  - Always: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUop=0, PCSource=0.
  - IRWrite=PCWrite=mem_ready.
  - Stay in FETCH while !mem_ready, else go to DECODE.
- DECODE:
  - Outputs: ALUSrcA=0, ALUSrcB=2, ALUop=0 (branch target).
  - Next state by opcode: 0 → REXEC; 1, 2 → IEXEC; 3, 4 → MEMADR; 5, 6 → BRANCH; 7 → JUMP; else → HALT.
- MEMADR:
  - Outputs: ALUSrcA=1, ALUSrcB=2, ALUop=0.
  - Next: opcode 3 → MEMRD, opcode 4 → MEMWR.
- MEMRD:
  - Outputs: MemRead=1, IorD=1.
  - Hold until mem_ready, then go to MEMWB.
- MEMWB:
  - Outputs: RegWrite=1, MemtoReg=1, RegDst=0.
  - Next: FETCH.
- MEMWR:
  - Outputs: MemWrite=1, IorD=1.
  - Hold until mem_ready, then go to FETCH.
- REXEC:
  - Outputs: ALUSrcA=1, ALUSrcB=0, ALUop=2.
  - Next: RWB.
- RWB:
  - Outputs: RegWrite=1, RegDst=1, MemtoReg=0.
  - Next: FETCH.
- IEXEC:
  - Outputs: ALUSrcA=1.
  - opcode 1: ALUSrcB=2, ALUop=0.
  - opcode 2: ALUSrcB=3, ALUop=3.
  - Next: IWB.
- IWB:
  - Outputs: RegWrite=1, RegDst=0, MemtoReg=0.
  - Next: FETCH.
- BRANCH:
  - Outputs: ALUSrcA=1, ALUSrcB=0, ALUop=1, PCWriteCond=1, PCSource=1, BranchNE=(opcode==6).
  - Next: FETCH.
- JUMP:
  - Outputs: PCWrite=1, PCSource=2.
  - Next: FETCH.
- HALT:
  - Outputs: halted=1, all others 0.
  - Stays in HALT until reset.
- opcode is sampled combinationally in DECODE, MEMADR, IEXEC and BRANCH. The IR is stable from DECODE onward.
- Reset:
  - While reset=1, all outputs are forced to 0, including MemRead in FETCH.
  - On a clock edge with reset=1, state goes to FETCH.
  - Reset in any state, including mid-wait in MEMRD/MEMWR, abandons the access. No write enable is asserted during the reset cycle.
- Latency without wait states:
  - R-type, addi and ori: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - beq, bne and j: 3 cycles
  - Each cycle in which mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.
- mem_ready is ignored in all states other than FETCH, MEMRD and MEMWR.

Test Plan:
- Reset for 2 cycles, then release with mem_ready=1 and opcode=0 → state sequence 0,1,6,7,0. ALUop=2 in REXEC. RegWrite=1 and RegDst=1 only in RWB.
- opcode=3 with mem_ready low for 3 cycles in MEMRD → state sequence 0,1,2,3,3,3,3,4,0. MemRead=IorD=1 throughout MEMRD. MemtoReg=RegWrite=1 in MEMWB.
- mem_ready=0 for 2 cycles in FETCH → state stays 0, MemRead=1, and IRWrite=PCWrite=0 until the mem_ready=1 cycle, where both are 1 for exactly one cycle.
- opcode=2 → IEXEC outputs ALUop=3 and ALUSrcB=3. opcode=6 → BRANCH outputs ALUop=1, PCWriteCond=1, BranchNE=1, PCSource=1.
- opcode=9 → DECODE then HALT, halted=1 for 10 cycles regardless of mem_ready. Asserting reset returns state to 0.
- Assert reset in MEMWR with mem_ready=0 → MemWrite=0 in the reset cycle, and state=0 on the next edge.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Main control unit for the multicycle 16-bit datapath: sequences
// fetch/decode/execute/memory/writeback from the 4-bit opcode and produces
// every datapath enable, mux select and the 2-bit ALUop for the ALU decoder.
// Latency: 3..5 cycles per instruction, plus one cycle per wait in FETCH/MEMRD/MEMWR.
// Backpressure: mem_ready low holds FETCH, MEMRD and MEMWR; illegal opcodes park in HALT.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   opcode                instr[15:12] from the instruction register
//   mem_ready             memory completes the current access this cycle
//   zero                  ALU zero flag (branch resolution happens in the datapath)
//   PCWrite..ALUop        datapath control, combinational from the registered state
//   state, halted         debug view of the current state, HALT indicator
module multicycle_control_fsm #(
   parameter int STATE_W = 4,
   parameter int OPC_W   = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [OPC_W-1:0]   opcode,
   input  logic               mem_ready,
   input  logic               zero,
   output logic               PCWrite,
   output logic               PCWriteCond,
   output logic               BranchNE,
   output logic [1:0]         PCSource,
   output logic               IorD,
   output logic               MemRead,
   output logic               MemWrite,
   output logic               IRWrite,
   output logic               RegDst,
   output logic               MemtoReg,
   output logic               RegWrite,
   output logic               ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic [1:0]         ALUop,
   output logic [STATE_W-1:0] state,
   output logic               halted
);

   typedef enum logic [STATE_W-1:0] {
      ST_FETCH  = STATE_W'(0),
      ST_DECODE = STATE_W'(1),
      ST_MEMADR = STATE_W'(2),
      ST_MEMRD  = STATE_W'(3),
      ST_MEMWB  = STATE_W'(4),
      ST_MEMWR  = STATE_W'(5),
      ST_REXEC  = STATE_W'(6),
      ST_RWB    = STATE_W'(7),
      ST_IEXEC  = STATE_W'(8),
      ST_IWB    = STATE_W'(9),
      ST_BRANCH = STATE_W'(10),
      ST_JUMP   = STATE_W'(11),
      ST_HALT   = STATE_W'(12)
   } state_t;

   localparam logic [OPC_W-1:0] OP_R    = OPC_W'(0);
   localparam logic [OPC_W-1:0] OP_ADDI = OPC_W'(1);
   localparam logic [OPC_W-1:0] OP_ORI  = OPC_W'(2);
   localparam logic [OPC_W-1:0] OP_LW   = OPC_W'(3);
   localparam logic [OPC_W-1:0] OP_SW   = OPC_W'(4);
   localparam logic [OPC_W-1:0] OP_BEQ  = OPC_W'(5);
   localparam logic [OPC_W-1:0] OP_BNE  = OPC_W'(6);
   localparam logic [OPC_W-1:0] OP_J    = OPC_W'(7);

   state_t cur;

   // Branch resolution is done by the datapath using PCWriteCond/BranchNE.
   logic unused_zero;
   assign unused_zero = zero;

   always_ff @(posedge clk) begin
      if (reset) begin
         cur <= ST_FETCH;
      end else begin
         case (cur)
            ST_FETCH:  if (mem_ready) cur <= ST_DECODE;
            ST_DECODE: begin
               if (opcode == OP_R)
                  cur <= ST_REXEC;
               else if (opcode == OP_ADDI || opcode == OP_ORI)
                  cur <= ST_IEXEC;
               else if (opcode == OP_LW || opcode == OP_SW)
                  cur <= ST_MEMADR;
               else if (opcode == OP_BEQ || opcode == OP_BNE)
                  cur <= ST_BRANCH;
               else if (opcode == OP_J)
                  cur <= ST_JUMP;
               else
                  cur <= ST_HALT;
            end
            // The IR cannot change after DECODE, so only lw/sw reach MEMADR;
            // anything else falls back to FETCH rather than wedging.
            ST_MEMADR: begin
               if (opcode == OP_LW)
                  cur <= ST_MEMRD;
               else if (opcode == OP_SW)
                  cur <= ST_MEMWR;
               else
                  cur <= ST_FETCH;
            end
            ST_MEMRD:  if (mem_ready) cur <= ST_MEMWB;
            ST_MEMWB:  cur <= ST_FETCH;
            ST_MEMWR:  if (mem_ready) cur <= ST_FETCH;
            ST_REXEC:  cur <= ST_RWB;
            ST_RWB:    cur <= ST_FETCH;
            ST_IEXEC:  cur <= ST_IWB;
            ST_IWB:    cur <= ST_FETCH;
            ST_BRANCH: cur <= ST_FETCH;
            ST_JUMP:   cur <= ST_FETCH;
            ST_HALT:   cur <= ST_HALT;
            default:   cur <= ST_FETCH;
         endcase
      end
   end

   // Reset masks every output in the same cycle, so an access that was
   // mid-wait is abandoned without a stray write or read strobe.
   always_comb begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      BranchNE    = 1'b0;
      PCSource    = 2'd0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      RegDst      = 1'b0;
      MemtoReg    = 1'b0;
      RegWrite    = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'd0;
      ALUop       = 2'd0;
      halted      = 1'b0;
      if (!reset) begin
         case (cur)
            ST_FETCH: begin
               // PC+1 computed every cycle, committed only when the fetch lands.
               MemRead = 1'b1;
               ALUSrcB = 2'd1;
               IRWrite = mem_ready;
               PCWrite = mem_ready;
            end
            ST_DECODE: ALUSrcB = 2'd2;   // speculative branch target into ALUOut
            ST_MEMADR: begin
               ALUSrcA = 1'b1;
               ALUSrcB = 2'd2;
            end
            ST_MEMRD: begin
               MemRead = 1'b1;
               IorD    = 1'b1;
            end
            ST_MEMWB: begin
               RegWrite = 1'b1;
               MemtoReg = 1'b1;
            end
            ST_MEMWR: begin
               MemWrite = 1'b1;
               IorD     = 1'b1;
            end
            ST_REXEC: begin
               ALUSrcA = 1'b1;
               ALUop   = 2'd2;
            end
            ST_RWB: begin
               RegWrite = 1'b1;
               RegDst   = 1'b1;
            end
            ST_IEXEC: begin
               ALUSrcA = 1'b1;
               if (opcode == OP_ADDI) begin
                  ALUSrcB = 2'd2;
               end else if (opcode == OP_ORI) begin
                  ALUSrcB = 2'd3;
                  ALUop   = 2'd3;
               end
            end
            ST_IWB: RegWrite = 1'b1;
            ST_BRANCH: begin
               ALUSrcA     = 1'b1;
               ALUop       = 2'd1;
               PCWriteCond = 1'b1;
               PCSource    = 2'd1;
               BranchNE    = (opcode == OP_BNE);
            end
            ST_JUMP: begin
               PCWrite  = 1'b1;
               PCSource = 2'd2;
            end
            ST_HALT: halted = 1'b1;
            default: ;
         endcase
      end
   end

   assign state = reset ? '0 : cur;

endmodule
